// File: rtl/cpc_ram_bank_ctrl.sv
// CPC RAM expansion: decodes &7Fxx RAM-config writes and maps 16KB windows
// onto internal or expansion SRAM pages, driving RAMDIS and SRAM strobes.
module cpc_ram_bank_ctrl #(
    parameter int BANK_BITS = 3,
    parameter int RAM_AW    = BANK_BITS + 16
) (
    input  logic                 CLK,
    input  logic                 RESET_B,
    input  logic [15:0]          A,
    input  logic [7:0]           D,
    input  logic                 IOREQ_B,
    input  logic                 MREQ_B,
    input  logic                 RD_B,
    input  logic                 WR_B,
    input  logic                 M1_B,
    input  logic                 RFSH_B,
    output logic                 RAMDIS,
    output logic [RAM_AW-1:0]    ram_addr,
    output logic                 ram_ce_b,
    output logic                 ram_oe_b,
    output logic                 ram_we_b,
    output logic [2:0]           cfg_q,
    output logic [BANK_BITS-1:0] bank_q
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t state, state_nxt;

    logic       iowr_hit;
    logic       io_idle;
    logic       load;
    logic       mem_act;
    logic       ext;
    logic [1:0] win;
    logic [2:0] page;

    assign iowr_hit = !IOREQ_B && !WR_B && M1_B && !A[15];
    assign io_idle  = IOREQ_B && WR_B;

    // One load per I/O cycle: WAIT absorbs the rest of the cycle.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iowr_hit) begin
                    state_nxt = ST_WAIT;
                    load      = (D[7:6] == 2'b11);
                end
            end
            ST_WAIT: begin
                if (io_idle)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_WAIT;
        endcase
    end

    // Resetting into WAIT drops any write still in flight at release.
    always_ff @(posedge CLK) begin
        if (!RESET_B) begin
            state  <= ST_WAIT;
            cfg_q  <= 3'd0;
            bank_q <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                cfg_q  <= D[2:0];
                bank_q <= D[BANK_BITS+2:3];
            end
        end
    end

    assign win = A[15:14];

    always_comb begin
        page = {1'b0, win};
        case (cfg_q)
            3'd1: begin
                if (win == 2'd3)
                    page = 3'd7;
            end
            3'd2: page = {1'b1, win};
            3'd3: begin
                if (win == 2'd1)
                    page = 3'd3;
                else if (win == 2'd3)
                    page = 3'd7;
            end
            3'd4, 3'd5, 3'd6, 3'd7: begin
                if (win == 2'd1)
                    page = cfg_q;
            end
            default: ;
        endcase
    end

    assign mem_act = !MREQ_B && RFSH_B;
    assign ext     = page[2] && mem_act;

    assign RAMDIS   = ext;
    assign ram_ce_b = !ext;
    assign ram_oe_b = ext ? RD_B : 1'b1;
    assign ram_we_b = ext ? WR_B : 1'b1;
    assign ram_addr = {bank_q, page[1:0], A[13:0]};

endmodule
